cnt_down: RTL and testbench
===========================

// Module: cnt_down
// PURPOSE
//  Loadable synchronous down-counter with built-in prescaler, complement to the up-counting sync counter.
//  A single-clock-domain prescaler produces one-cycle count ticks, and each tick decrements a WIDTH-bit value toward zero.
//  The block reports terminal count and either stops or auto-reloads.
//  Drives countdown/timeout displays; consumes load values from control logic.
// PARAMETERS
//  WIDTH   4   width of count value and load value
//  DIV     5   prescaler ratio: one tick every DIV clk cycles while running (DIV >= 2)
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  rst         in   1      asynchronous, active-high reset
//  load        in   1      sync load strobe: out <= load_val
//  load_val    in   WIDTH  value captured on load; also the auto-reload value
//  start       in   1      begin counting (accepted in IDLE only)
//  auto_reload in   1      1: reload load_val at zero and keep running; 0: stop at zero
//  out         out  WIDTH  current count
//  out_clk     out  1      square wave, toggles on every tick while RUN
//  tc          out  1      one-cycle terminal-count pulse
//  busy        out  1      high while in RUN
// BEHAVIOUR
//  Reset (rst=1, async): state=IDLE, out=0, out_clk=0, tc=0, busy=0, prescaler=0, stored reload=0.
//  All outputs are registered.
//  Prescaler:
//   - counts 0..DIV-1 only in RUN; holds in IDLE and DONE.
//   - tick = RUN && pre==DIV-1; pre wraps to 0 on that cycle.
//   - The first tick after start comes DIV cycles after the start edge.
//  States:
//   - IDLE: out holds.
//     - start && out!=0 -> RUN, pre=0.
//     - start && out==0 -> DONE, tc=1 next cycle.
//   - RUN: busy=1. On each tick, out_clk toggles and:
//     - out>1: out <= out-1.
//     - out==1: out <= 0, tc=1 in the same cycle out first reads 0.
//       - auto_reload=0 -> DONE.
//       - auto_reload=1 -> stay RUN.
//     - out==0 (reached only via auto_reload): out <= stored reload value, no tc.
//       - If the stored reload value is 0, out stays 0 and tc pulses every tick.
//   - DONE: out holds 0, busy=0. start is ignored; only load leaves DONE.
//  load (any state, highest priority):
//   - out <= load_val, stored reload <= load_val.
//   - pre=0, out_clk=0, tc=0, state -> IDLE.
//  load && start in the same cycle: load wins, start is dropped.
//  auto_reload is sampled at the tick where out goes 1->0; changes between ticks have no effect.
//  tc is high for exactly one clk cycle per terminal event and never coincides with load.
//  rst asserted mid-RUN: immediate return to reset values; no tc is emitted.
//  Count arithmetic is WIDTH-bit unsigned; there is no decrement below 0.
// TESTING  (DIV=5, WIDTH=4)
//  1. Reset: rst=1 mid-RUN with out=7 -> out=0, busy=0, out_clk=0, tc=0 immediately (async).
//  2. Basic countdown: load 3, start, auto_reload=0.
//     -> out goes 3,2,1,0 at cycles +5,+10,+15 after start.
//     -> tc high one cycle with out=0; state DONE, busy=0.
//     -> out_clk toggles 3 times.
//  3. Auto-reload: load 2, start, auto_reload=1.
//     -> out sequence 2,1,0,2,1,0..., one tick apart.
//     -> tc pulses at every 1->0 step, one per 15-cycle period; busy stays 1.
//  4. Zero start: load 0, start -> DONE next cycle, tc pulse once, out stays 0.
//  5. Priority: load=1 with load_val=9 and start=1 in the same cycle during RUN.
//     -> out=9, IDLE, out_clk=0.
//     -> a start one cycle later yields the first decrement 5 cycles after it.
//  6. Wrap boundary: load 15, auto_reload=1.
//     -> counts 15..0, then reloads 15.
//     -> tc exactly once per 16 ticks; no out value above 15.

Source files
------------

// File: rtl/cnt_down_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnt_down_if : control/status bundle for the cnt_down counter (r1.0) |
// +--------------------------------------------------------------------+
interface cnt_down_if #(
  parameter int WIDTH = 4
);
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic             start_i;
  logic             auto_reload_i;
  logic [WIDTH-1:0] out_o;
  logic             out_clk_o;
  logic             tc_o;
  logic             busy_o;

  modport master (
    output load_i, load_val_i, start_i, auto_reload_i,
    input  out_o, out_clk_o, tc_o, busy_o
  );

  modport slave (
    input  load_i, load_val_i, start_i, auto_reload_i,
    output out_o, out_clk_o, tc_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/cnt_down.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnt_down : loadable prescaled down-counter with tc and reload (r1.0)|
// +--------------------------------------------------------------------+
module cnt_down #(
  parameter int WIDTH = 4,
  parameter int DIV   = 5
) (
  input  wire logic  clk,
  input  wire logic  rst,
  cnt_down_if.slave  bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    pre_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] reload_q;
  logic             out_clk_q;
  logic             tc_q;
  logic             busy_q;
  logic             tick_w;

  assign tick_w = (state_q == S_RUN) && (pre_q == PW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      out_q     <= '0;
      reload_q  <= '0;
      out_clk_q <= 1'b0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.load_i) begin
        state_q   <= S_IDLE;
        pre_q     <= '0;
        out_q     <= bus.load_val_i;
        reload_q  <= bus.load_val_i;
        out_clk_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start_i) begin
              pre_q <= '0;
              if (out_q != '0) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
              end else begin
                state_q <= S_DONE;
                tc_q    <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (tick_w) begin
              pre_q     <= '0;
              out_clk_q <= ~out_clk_q;
              if (out_q > WIDTH'(1)) begin
                out_q <= out_q - WIDTH'(1);
              end else if (out_q == WIDTH'(1)) begin
                out_q <= '0;
                tc_q  <= 1'b1;
                if (!bus.auto_reload_i) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                end
              end else begin
                // Zero only persists in RUN under auto-reload; a zero reload value keeps terminating.
                out_q <= reload_q;
                if (reload_q == '0) begin
                  tc_q <= 1'b1;
                end
              end
            end else begin
              pre_q <= pre_q + PW'(1);
            end
          end
          S_DONE: begin
            state_q <= S_DONE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_o     = out_q;
  assign bus.out_clk_o = out_clk_q;
  assign bus.tc_o      = tc_q;
  assign bus.busy_o    = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_cnt_down.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cnt_down : self-checking bench for cnt_down (r1.0)               |
// +--------------------------------------------------------------------+
module tb_cnt_down;
  localparam int WIDTH = 4;
  localparam int DIV   = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  string phase = "init";

  cnt_down_if #(.WIDTH(WIDTH)) bus ();

  cnt_down #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: expected outputs derived from cycles elapsed since start.
  int   m_mode;   // 0 idle, 1 run, 2 done
  int   m_L;
  int   m_n;
  bit   m_ar;
  logic [31:0] e_out, e_clk, e_tc, e_busy;

  task automatic model_reset();
    m_mode = 0; m_L = 0; m_n = 0; m_ar = 1'b0;
    e_out = 0; e_clk = 0; e_tc = 0; e_busy = 0;
  endtask

  task automatic model_edge(input bit ld, input int v, input bit st);
    int k;
    e_tc = 0;
    if (ld) begin
      m_mode = 0; m_L = v; e_out = v; e_clk = 0; e_busy = 0;
    end else if (m_mode == 0 && st) begin
      if (m_L == 0) begin
        m_mode = 2; e_tc = 1; e_out = 0;
      end else begin
        m_mode = 1; m_n = 0; m_ar = bus.auto_reload_i; e_busy = 1;
      end
    end else if (m_mode == 1) begin
      m_n++;
      k = m_n / DIV;
      e_clk = k % 2;
      if (m_ar) begin
        e_out = m_L - (k % (m_L + 1));
        e_tc  = ((m_n % DIV) == 0) && ((k % (m_L + 1)) == m_L);
      end else if ((m_n % DIV) == 0 && k == m_L) begin
        e_out = 0; e_tc = 1; m_mode = 2; e_busy = 0;
      end else begin
        e_out = m_L - k;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out",     32'(bus.out_o),     e_out);
    chk("out_clk", 32'(bus.out_clk_o), e_clk);
    chk("tc",      32'(bus.tc_o),      e_tc);
    chk("busy",    32'(bus.busy_o),    e_busy);
  endtask

  task automatic step(input bit ld, input int v, input bit st, input bit ar);
    bus.load_i        = ld;
    bus.load_val_i    = v[WIDTH-1:0];
    bus.start_i       = st;
    bus.auto_reload_i = ar;
    @(posedge clk);
    model_edge(ld, v, st);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input bit ar);
    repeat (n) step(1'b0, 0, 1'b0, ar);
  endtask

  task automatic async_reset_check();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    int tc_cnt;
    bit ar_cur;
    rst = 1'b1;
    bus.load_i = 1'b0; bus.load_val_i = '0; bus.start_i = 1'b0; bus.auto_reload_i = 1'b0;
    model_reset();
    #2;
    phase = "reset";
    check_all();
    @(negedge clk);
    rst = 1'b0;

    phase = "basic";
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(20, 1'b0);
    chk("done_out", 32'(bus.out_o), 0);

    phase = "rst_mid_run";
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(11, 1'b0);
    chk("pre_rst_out", 32'(bus.out_o), 7);
    async_reset_check();

    phase = "auto_reload";
    step(1'b1, 2, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    tc_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      idle(1, 1'b1);
      tc_cnt += int'(bus.tc_o);
    end
    chk("tc_count", 32'(tc_cnt), 3);

    phase = "zero_start";
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(2, 1'b0);

    phase = "priority";
    step(1'b1, 4, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(7, 1'b0);
    step(1'b1, 9, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(12, 1'b0);

    phase = "wrap15";
    step(1'b1, 15, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    tc_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      idle(1, 1'b1);
      tc_cnt += int'(bus.tc_o);
    end
    chk("tc_count", 32'(tc_cnt), 2);

    phase = "random";
    ar_cur = 1'b0;
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (m_mode != 1 && $urandom_range(0, 3) == 0) ar_cur = 1'($urandom_range(0, 1));
      step(r < 5, int'($urandom_range(0, 15)), (r >= 5 && r < 20), ar_cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
